sdram_block_mover: RTL and testbench
====================================

SDRAM_BLOCK_MOVER -- requirements
Module: sdram_block_mover

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 32, Avalon byte-address width.
REQ-002 DATA_W, 16, word width, matching the SDRAM data bus.
REQ-003 BURST_MAX, 8, maximum beats per burst (power of 2).
REQ-004 FIFO_DEPTH, 8, beat buffer depth; SHALL be >= BURST_MAX.
REQ-005 Ports (name, direction, width, meaning); clock and reset listed first.
- clk, in, 1: the single clock. reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: level from HPS PIO (startsig).
- src_addr, in, ADDR_W: source byte address. dst_addr, in, ADDR_W: destination byte address.
- len_words, in, 16: number of words to move. invert, in, 1: XOR each word with all-ones.
- busy, out, 1: transfer in progress. done, out, 1: completion flag to HPS PIO (donesig).
- m_address, out, ADDR_W. m_burstcount, out, 4. m_read, out, 1. m_write, out, 1. m_writedata, out, DATA_W.
- m_waitrequest, in, 1. m_readdata, in, DATA_W. m_readdatavalid, in, 1.

Function
REQ-006 A transfer SHALL launch only on a rising edge of start, registered, while in IDLE; src_addr, dst_addr, len_words and invert SHALL be latched on that cycle.
REQ-007 The FSM states SHALL be IDLE, RD_REQ, RD_DATA, WR_BURST and FINISH.
REQ-008 IDLE transitions to RD_REQ on launch, or to FINISH when len_words=0 (no bus cycles issued).
REQ-009 RD_REQ: m_read=1, m_address=current src, m_burstcount=min(BURST_MAX, remaining); held until m_waitrequest=0, then go to RD_DATA.
REQ-010 RD_DATA: each m_readdatavalid beat SHALL push (m_readdata XOR {DATA_W{invert}}) into the FIFO; after burstcount beats, go to WR_BURST.
REQ-011 WR_BURST: m_write=1, with m_address=current dst and m_burstcount held constant for the whole burst; m_writedata=FIFO head; a beat is consumed only on a cycle where m_waitrequest=0.
REQ-012 After the last write beat: src and dst SHALL advance by burstcount*DATA_W/8 bytes and remaining decrements by burstcount; go to RD_REQ if remaining>0, else FINISH.
REQ-013 FINISH SHALL set done=1 and busy=0, then return to IDLE; done SHALL stay high until the next launch clears it.
REQ-014 busy SHALL be 1 from the cycle after launch through the last write beat.
REQ-015 m_read and m_write SHALL never be asserted together; both are 0 in IDLE and FINISH.
REQ-016 A start edge while busy SHALL be ignored.
REQ-017 A final partial burst (remaining < BURST_MAX) SHALL use burstcount=remaining.
REQ-018 Address arithmetic SHALL wrap modulo 2^ADDR_W without error.
REQ-019 Readdatavalid beats arriving outside RD_DATA SHALL be dropped; the FIFO never overflows because one read burst at most fills it.

Reset
REQ-020 When reset_n=0 at a clk edge, the block SHALL enter IDLE and clear busy, done, m_read, m_write, m_address, m_burstcount, m_writedata, the FIFO pointers, the counters and the start-edge register.
REQ-021 Reset mid-burst SHALL abandon the transfer immediately; no further bus requests are issued.

Structure
REQ-022 The FSM state enum and the BURST_MAX/FIFO_DEPTH defaults SHALL live in package sdram_mover_pkg.
REQ-023 The beat buffer SHALL be the sub-module sync_fifo: single clock, push/pop/full/empty, registered head.

Verification
REQ-024 len=20, src=0x0000_1000, dst=0x0000_2000, invert=0, zero-wait memory: bursts of 8, 8 and 4 at dst 0x2000, 0x2010 and 0x2020; dst content equals src; done=1.
REQ-025 invert=1, src words 0x00FF and 0xA5A5, len=2: writes 0xFF00 and 0x5A5A with burstcount=2.
REQ-026 len=0: done=1 within 2 cycles of the start edge; m_read and m_write never assert.
REQ-027 Random m_waitrequest (50%) and readdatavalid gaps, len=37: data matches in order; m_address and m_burstcount are stable during each write burst.
REQ-028 Second start edge mid-transfer: ignored, exactly len writes occur; after start falls and rises again, done clears and a new transfer runs.
REQ-029 reset_n=0 during WR_BURST beat 3: next cycle m_write=0, busy=0, done=0, state IDLE.

Source files
------------

// File: rtl/sdram_mover_pkg.sv
// Shared FSM encoding and sizing defaults for the SDRAM block mover.
package sdram_mover_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    FINISH
  } mover_state_t;

  localparam int BURST_MAX_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 8;

  // Beats in the current burst: the full burst size, or whatever is left if smaller.
  function automatic logic [3:0] burst_len(input logic [15:0] remaining, input int burst_max);
    burst_len = (remaining < 16'(burst_max)) ? remaining[3:0] : 4'(burst_max);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock beat buffer with a registered head word (first-word fall-through).
// Push/pop act on the clock edge; a push when full or a pop when empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic [CNT_W-1:0] count;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign wr_next = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_next = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_next;
      if (pop_ok)  rd_ptr <= rd_next;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head tracks the oldest entry; a push into an empty (or emptying) buffer bypasses mem.
      if (pop_ok && count > CNT_W'(1))
        head <= mem[rd_next];
      else if (push_ok && (empty || (pop_ok && count == CNT_W'(1))))
        head <= din;
    end
  end

endmodule

// File: rtl/sdram_block_mover.sv
// Avalon-MM burst copier: reads up to BURST_MAX words from src, optionally inverts, writes them to dst.
// Launches on a registered start rise; bursts stall on m_waitrequest; done holds until the next launch.
module sdram_block_mover
  import sdram_mover_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int BURST_MAX  = BURST_MAX_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       len_words,
  input  logic              invert,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_burstcount,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid
);

  localparam int BYTES = DATA_W / 8;

  mover_state_t      state, state_nxt;
  logic              start_q;
  logic [ADDR_W-1:0] src_cur, dst_cur, step;
  logic [15:0]       remaining;
  logic              inv_q;
  logic [3:0]        beat_cnt, burst;
  logic              launch, fifo_push, fifo_pop, last_rd, last_wr;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;

  // remaining only changes after the last write beat, so burst is stable across a read/write pair.
  assign burst     = burst_len(remaining, BURST_MAX);
  assign step      = ADDR_W'(burst) * ADDR_W'(BYTES);
  assign launch    = start && !start_q && (state == IDLE);
  assign fifo_push = (state == RD_DATA) && m_readdatavalid;
  assign fifo_pop  = (state == WR_BURST) && !m_waitrequest;
  assign last_rd   = fifo_push && (beat_cnt == burst - 4'd1);
  assign last_wr   = fifo_pop && (beat_cnt == burst - 4'd1);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_beat_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (m_readdata ^ {DATA_W{inv_q}}),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      src_cur   <= '0;
      dst_cur   <= '0;
      remaining <= '0;
      inv_q     <= 1'b0;
      beat_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      if (launch) begin
        src_cur   <= src_addr;
        dst_cur   <= dst_addr;
        remaining <= len_words;
        inv_q     <= invert;
        done      <= 1'b0;
      end
      if (state == FINISH) done <= 1'b1;
      if (last_rd || last_wr)
        beat_cnt <= '0;
      else if (fifo_push || fifo_pop)
        beat_cnt <= beat_cnt + 4'd1;
      if (last_wr) begin
        src_cur   <= src_cur + step;
        dst_cur   <= dst_cur + step;
        remaining <= remaining - 16'(burst);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_burstcount = '0;
    m_writedata  = '0;
    case (state)
      IDLE: begin
        if (launch) state_nxt = (len_words == 16'd0) ? FINISH : RD_REQ;
      end
      RD_REQ: begin
        busy         = 1'b1;
        m_read       = 1'b1;
        m_address    = src_cur;
        m_burstcount = burst;
        if (!m_waitrequest) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        busy = 1'b1;
        if (last_rd) state_nxt = WR_BURST;
      end
      WR_BURST: begin
        busy         = 1'b1;
        m_write      = 1'b1;
        m_address    = dst_cur;
        m_burstcount = burst;
        m_writedata  = fifo_head;
        if (last_wr) state_nxt = (remaining == 16'(burst)) ? FINISH : RD_REQ;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_block_mover.sv
// Bench for sdram_block_mover: Avalon slave memory with random stalls/gaps/stray beats,
// transfers checked against a burst-chunking reference model.
module tb_sdram_block_mover;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        invert;
  logic        busy, done;
  logic [31:0] m_address;
  logic [3:0]  m_burstcount;
  logic        m_read, m_write;
  logic [15:0] m_writedata;
  logic        m_waitrequest;
  logic [15:0] m_readdata;
  logic        m_readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [logic [31:0]];
  logic [31:0] rd_q[$];
  logic [15:0] wr_data_q[$];
  logic [31:0] burst_addr_q[$];
  logic [3:0]  burst_bc_q[$];
  logic [15:0] seed_q[$];

  bit          wait_mode, gap_mode, stray_mode;
  int          both_cnt, stab_cnt, act_cnt, wbeat;
  logic [31:0] wb_addr;
  logic [3:0]  wb_bc;

  sdram_block_mover dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len_words       (len_words),
    .invert          (invert),
    .busy            (busy),
    .done            (done),
    .m_address       (m_address),
    .m_burstcount    (m_burstcount),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave memory: inputs for the next edge are chosen at negedge, then the handshakes they allow are logged.
  initial begin
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    wbeat = 0; wb_addr = '0; wb_bc = '0;
    forever begin
      @(negedge clk);
      if (m_read && m_write) both_cnt++;
      if (m_read || m_write) act_cnt++;
      if (!reset_n) begin
        rd_q.delete();
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; wbeat = 0;
        continue;
      end
      m_waitrequest = wait_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rd_q.size() > 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
        m_readdata = mem[rd_q.pop_front()];
        m_readdatavalid = 1'b1;
      end else if (stray_mode && rd_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        m_readdata = 16'($urandom);
        m_readdatavalid = 1'b1;
      end else begin
        m_readdata = 16'($urandom);
        m_readdatavalid = 1'b0;
      end
      if (m_read && !m_waitrequest)
        for (int i = 0; i < int'(m_burstcount); i++) rd_q.push_back(m_address + 32'(2 * i));
      if (m_write) begin
        if (wbeat == 0) begin
          wb_addr = m_address; wb_bc = m_burstcount;
        end else if (m_address !== wb_addr || m_burstcount !== wb_bc) begin
          stab_cnt++;
        end
        if (!m_waitrequest) begin
          mem[wb_addr + 32'(2 * wbeat)] = m_writedata;
          wr_data_q.push_back(m_writedata);
          wbeat++;
          if (wbeat == int'(wb_bc)) begin
            burst_addr_q.push_back(wb_addr);
            burst_bc_q.push_back(wb_bc);
            wbeat = 0;
          end
        end
      end
    end
  end

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input logic inv, input bit retrig);
    logic [15:0] exp_q[$];
    logic [15:0] w;
    logic [31:0] ea;
    int rem, bc, k, cyc;
    for (int i = 0; i < n; i++) begin
      w = (seed_q.size() > 0) ? seed_q.pop_front() : 16'($urandom);
      mem[s + 32'(2 * i)] = w;
      exp_q.push_back(w ^ {16{inv}});
    end
    wr_data_q.delete(); burst_addr_q.delete(); burst_bc_q.delete();
    both_cnt = 0; stab_cnt = 0;
    src_addr = s; dst_addr = d; len_words = 16'(n); invert = inv;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("done_clr", 32'(done), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (retrig && cyc == 6) start = 1'b0;
      if (retrig && cyc == 8) start = 1'b1;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("n_writes", 32'(wr_data_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk("data", (i < wr_data_q.size()) ? 32'(wr_data_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    rem = n; ea = d; k = 0;
    while (rem > 0) begin
      bc = (rem < 8) ? rem : 8;
      chk("b_addr", (k < burst_addr_q.size()) ? burst_addr_q[k] : 32'hFFFF_FFFF, ea);
      chk("b_cnt", (k < burst_bc_q.size()) ? 32'(burst_bc_q[k]) : 32'hFFFF_FFFF, 32'(bc));
      ea = ea + 32'(2 * bc); rem -= bc; k++;
    end
    chk("n_bursts", 32'(burst_addr_q.size()), 32'(k));
    chk("rw_excl", 32'(both_cnt), 32'd0);
    chk("w_stable", 32'(stab_cnt), 32'd0);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0; invert = 1'b0;
    wait_mode = 0; gap_mode = 0; stray_mode = 0;
    both_cnt = 0; stab_cnt = 0; act_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read", 32'(m_read), 32'd0);
    chk("rst_write", 32'(m_write), 32'd0);
    chk("rst_addr", m_address, 32'd0);
    chk("rst_bc", 32'(m_burstcount), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(sdram_mover_pkg::IDLE));
    reset_n = 1'b1;

    run_xfer(32'h0000_1000, 32'h0000_2000, 20, 1'b0, 1'b0);

    seed_q = '{16'h00FF, 16'hA5A5};
    run_xfer(32'h0000_3000, 32'h0000_4000, 2, 1'b1, 1'b0);

    // Zero-length launch: only done should move.
    len_words = 16'd0; act_cnt = 0;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 2) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("len0_done", 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("len0_quiet", 32'(act_cnt), 32'd0);

    wait_mode = 1; gap_mode = 1; stray_mode = 1;
    run_xfer(32'h0000_5000, 32'h0000_6000, 37, 1'b0, 1'b1);
    run_xfer(32'h0000_7000, 32'h0000_8000, 11, 1'b1, 1'b0);
    run_xfer(32'hFFFF_FFF8, 32'h0030_0000, 12, 1'b0, 1'b0);
    run_xfer(32'h0040_0000, 32'hFFFF_FFF0, 12, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++)
      run_xfer(32'h0001_0000 + 32'($urandom_range(0, 255)) * 32'd256,
               32'h0080_0000 + 32'($urandom_range(0, 255)) * 32'd256,
               $urandom_range(1, 40), 1'($urandom_range(0, 1)), 1'b0);

    // Reset while the fourth beat of the first write burst is on the bus.
    wait_mode = 0; gap_mode = 0; stray_mode = 0;
    wr_data_q.delete();
    src_addr = 32'h0000_9000; dst_addr = 32'h0000_A000; len_words = 16'd16; invert = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (wr_data_q.size() < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_mid_beats", 32'(wr_data_q.size()), 32'd3);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_write", 32'(m_write), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_state", 32'(dut.state), 32'(sdram_mover_pkg::IDLE));
    act_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_quiet", 32'(act_cnt), 32'd0);
    chk("rst_idle_busy", 32'(busy), 32'd0);

    run_xfer(32'h0000_B000, 32'h0000_C000, 9, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
